// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes field-level instruction requests and streams them into instruction memory
// Writes land one cycle after accept; the first illegal request halts the session until start or reset.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [2:0]        i_fmt,
  input  logic [2:0]        i_op,
  input  logic [2:0]        i_ra,
  input  logic [2:0]        i_rb,
  input  logic [7:0]        i_imm,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [8:0]        o_wr_data,
  output logic              o_done,
  output logic              o_full,
  output logic              o_err,
  output logic [2:0]        o_err_code,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [8:0]          r_wr_data;
  logic                r_done;
  logic                r_full;
  logic                r_err;
  logic [2:0]          r_err_code;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_ptr;
  logic [8:0]          w_enc;
  logic [2:0]          w_code;
  logic                w_ready;
  logic                w_accept;

  // Count already includes the word pending in the write stage, so it alone gates readiness.
  assign w_ready  = (r_state == ACTIVE) && !i_start && (r_count < LP_DEPTH);
  assign w_accept = i_in_valid && w_ready;

  always_comb begin
    w_enc  = 9'd0;
    w_code = 3'd0;
    case (i_fmt)
      3'd0: begin
        w_enc = {2'b00, i_op[0], i_ra, i_rb};
        if (i_op > 3'd1) w_code = 3'd4;
      end
      3'd1: begin
        w_enc = {2'b01, i_op, i_ra[1:0], i_rb[1:0]};
        if (i_ra[2] || i_rb[2]) w_code = 3'd2;
      end
      3'd2: begin
        w_enc = {3'b100, i_op[1:0], i_imm[3:0]};
        if (i_imm[7:4] != 4'd0) w_code = 3'd3;
        else if (i_op[2])       w_code = 3'd4;
      end
      3'd3: begin
        w_enc = {4'b1010, i_op[1:0], i_ra};
        if (i_op[2]) w_code = 3'd4;
      end
      3'd4: begin
        w_enc = {4'b1011, i_op[1:0], i_ra};
        if (i_op[2]) w_code = 3'd4;
      end
      3'd5: begin
        w_enc = {5'b11000, i_op[0], i_imm[2:0]};
        if (i_imm[7:3] != 5'b01000) w_code = 3'd3;
        else if (i_op > 3'd1)       w_code = 3'd4;
      end
      default: w_code = 3'd1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_start) begin
      w_next = ACTIVE;
    end else if (r_state == ACTIVE && w_accept) begin
      if (w_code != 3'd0)                                   w_next = ERROR;
      else if (i_in_last || (r_count + 1'b1) == LP_DEPTH)  w_next = DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 9'd0;
      r_done     <= 1'b0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_count    <= '0;
      r_ptr      <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (i_start) begin
        r_done     <= 1'b0;
        r_full     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= 3'd0;
        r_count    <= '0;
        r_ptr      <= '0;
      end else begin
        if (w_accept) begin
          if (w_code == 3'd0) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr;
            r_wr_data <= w_enc;
            r_ptr     <= r_ptr + 1'b1;
            r_count   <= r_count + 1'b1;
          end else begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
          end
        end
        // DONE is entered with the final write, so done trails wr_en by one cycle.
        if (r_state == DONE) begin
          r_done <= 1'b1;
          r_full <= (r_count == LP_DEPTH);
        end
      end
    end
  end

  assign o_in_ready = w_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_done     = r_done;
  assign o_full     = r_full;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_count    = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  logic [2:0] fmt = 3'd0;
  logic [2:0] op = 3'd0;
  logic [2:0] ra = 3'd0;
  logic [2:0] rb = 3'd0;
  logic [7:0] imm = 8'd0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       done;
  logic       full;
  logic       err;
  logic [2:0] err_code;
  logic [8:0] count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_last(in_last), .i_fmt(fmt), .i_op(op),
    .i_ra(ra), .i_rb(rb), .i_imm(imm), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_done(done), .o_full(full), .o_err(err),
    .o_err_code(err_code), .o_count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_last = 1'b0; fmt = 3'd0; op = 3'd0; ra = 3'd0; rb = 3'd0; imm = 8'd0;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [2:0] o, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] i, input logic l);
    in_valid = 1'b1; fmt = f; op = o; ra = a; rb = b; imm = i; in_last = l;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
    total++; if (wr_addr !== 8'd0) begin bad++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    total++; if (wr_data !== 9'd0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err_code got=%0h exp=0", err_code); end
    total++; if (count !== 9'd0) begin bad++; $display("FAIL reset_count got=%0h exp=0", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
  endtask

  task automatic test_single();
    do_start();
    set_req(3'd0, 3'd1, 3'd5, 3'd2, 8'd0, 1'b1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h exp=1", in_ready); end
    tick();
    idle_inputs();
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%0h exp=1", wr_en); end
    total++; if (wr_addr !== 8'd0) begin bad++; $display("FAIL single_wr_addr got=%0h exp=0", wr_addr); end
    total++; if (wr_data !== 9'h06A) begin bad++; $display("FAIL single_wr_data got=%0h exp=06a", wr_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_early got=%0h exp=0", done); end
    tick();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_wr_en_drop got=%0h exp=0", wr_en); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%0h exp=1", done); end
    total++; if (count !== 9'd1) begin bad++; $display("FAIL single_count got=%0h exp=1", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL single_full got=%0h exp=0", full); end
  endtask

  task automatic test_back_to_back();
    do_start();
    set_req(3'd2, 3'd1, 3'd0, 3'd0, 8'd9, 1'b0);
    tick();
    set_req(3'd3, 3'd2, 3'd7, 3'd0, 8'd0, 1'b0);
    total++; if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 9'h119) begin bad++; $display("FAIL b2b_w0 got=%0h@%0h en=%0h exp=119@0", wr_data, wr_addr, wr_en); end
    tick();
    set_req(3'd5, 3'd1, 3'd0, 3'd0, 8'h43, 1'b1);
    total++; if (wr_en !== 1'b1 || wr_addr !== 8'd1 || wr_data !== 9'h157) begin bad++; $display("FAIL b2b_w1 got=%0h@%0h en=%0h exp=157@1", wr_data, wr_addr, wr_en); end
    tick();
    idle_inputs();
    total++; if (wr_en !== 1'b1 || wr_addr !== 8'd2 || wr_data !== 9'h18B) begin bad++; $display("FAIL b2b_w2 got=%0h@%0h en=%0h exp=18b@2", wr_data, wr_addr, wr_en); end
    tick();
    total++; if (done !== 1'b1 || count !== 9'd3) begin bad++; $display("FAIL b2b_end got done=%0h count=%0d exp done=1 count=3", done, count); end
  endtask

  task automatic test_boundary_fields();
    do_start();
    set_req(3'd2, 3'd3, 3'd7, 3'd7, 8'd15, 1'b0);
    tick();
    set_req(3'd1, 3'd7, 3'd3, 3'd3, 8'hFF, 1'b0);
    total++; if (wr_en !== 1'b1 || wr_data !== 9'h13F) begin bad++; $display("FAIL bnd_jmp got=%0h en=%0h exp=13f", wr_data, wr_en); end
    tick();
    set_req(3'd5, 3'd1, 3'd7, 3'd7, 8'h47, 1'b1);
    total++; if (wr_en !== 1'b1 || wr_data !== 9'h0FF) begin bad++; $display("FAIL bnd_rr2 got=%0h en=%0h exp=0ff", wr_data, wr_en); end
    tick();
    idle_inputs();
    total++; if (wr_en !== 1'b1 || wr_data !== 9'h18F || err !== 1'b0) begin bad++; $display("FAIL bnd_memi got=%0h en=%0h err=%0h exp=18f", wr_data, wr_en, err); end
    tick();
  endtask

  task automatic test_error();
    do_start();
    set_req(3'd1, 3'd0, 3'd4, 3'd0, 8'd0, 1'b0);
    tick();
    idle_inputs();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL err_wr_en got=%0h exp=0", wr_en); end
    total++; if (err !== 1'b1 || err_code !== 3'd2) begin bad++; $display("FAIL err_reg got err=%0h code=%0h exp err=1 code=2", err, err_code); end
    total++; if (count !== 9'd0) begin bad++; $display("FAIL err_count got=%0d exp=0", count); end
    set_req(3'd7, 3'd0, 3'd0, 3'd0, 8'd0, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_ready got=%0h exp=0", in_ready); end
    tick();
    idle_inputs();
    total++; if (err_code !== 3'd2 || done !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL err_hold got code=%0h done=%0h en=%0h exp code=2 done=0 en=0", err_code, done, wr_en); end
    do_start();
    #1;
    total++; if (err !== 1'b0 || err_code !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL err_clear got err=%0h code=%0h ready=%0h exp 0 0 1", err, err_code, in_ready); end
  endtask

  task automatic test_err_codes();
    logic [2:0] v_fmt[5]  = '{3'd5, 3'd2, 3'd0, 3'd6, 3'd2};
    logic [2:0] v_op[5]   = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd4};
    logic [7:0] v_imm[5]  = '{8'h48, 8'd16, 8'd0, 8'd0, 8'd20};
    logic [2:0] v_code[5] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd3};
    for (int i = 0; i < 5; i++) begin
      do_start();
      set_req(v_fmt[i], v_op[i], 3'd0, 3'd0, v_imm[i], 1'b1);
      tick();
      idle_inputs();
      total++; if (err !== 1'b1 || err_code !== v_code[i] || wr_en !== 1'b0) begin bad++; $display("FAIL code_%0d got err=%0h code=%0h en=%0h exp err=1 code=%0h en=0", i, err, err_code, wr_en, v_code[i]); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL code_done_%0d got=%0h exp=0", i, done); end
    end
  endtask

  task automatic test_fill();
    do_start();
    set_req(3'd0, 3'd0, 3'd1, 3'd2, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h exp=1", i, in_ready); end
      tick();
      total++; if (wr_en !== 1'b1 || wr_addr !== 8'(i) || wr_data !== 9'h00A) begin bad++; $display("FAIL fill_w%0d got=%0h@%0h en=%0h exp=00a@%0h", i, wr_data, wr_addr, wr_en, i); end
    end
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_low got=%0h exp=0", in_ready); end
    tick();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL fill_extra_write got=%0h exp=0", wr_en); end
    total++; if (full !== 1'b1 || done !== 1'b1 || count !== 9'd4) begin bad++; $display("FAIL fill_end got full=%0h done=%0h count=%0d exp 1 1 4", full, done, count); end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_start();
    set_req(3'd0, 3'd1, 3'd5, 3'd2, 8'd0, 1'b0);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 9'd0) begin bad++; $display("FAIL mrst_wr got en=%0h addr=%0h data=%0h exp all 0", wr_en, wr_addr, wr_data); end
    total++; if (count !== 9'd0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mrst_state got count=%0d done=%0h err=%0h ready=%0h exp all 0", count, done, err, in_ready); end
    do_start();
    set_req(3'd0, 3'd1, 3'd5, 3'd2, 8'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    total++; if (wr_en !== 1'b0 || count !== 9'd0) begin bad++; $display("FAIL mrst_same_cycle got en=%0h count=%0d exp 0 0", wr_en, count); end
  endtask

  task automatic test_mid_start();
    do_start();
    set_req(3'd3, 3'd2, 3'd7, 3'd0, 8'd0, 1'b0);
    tick();
    set_req(3'd2, 3'd1, 3'd0, 3'd0, 8'd9, 1'b0);
    start = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mstart_ready got=%0h exp=0", in_ready); end
    tick();
    start = 1'b0;
    total++; if (wr_en !== 1'b0 || count !== 9'd0) begin bad++; $display("FAIL mstart_drop got en=%0h count=%0d exp 0 0", wr_en, count); end
    set_req(3'd0, 3'd1, 3'd5, 3'd2, 8'd0, 1'b1);
    tick();
    idle_inputs();
    total++; if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 9'h06A) begin bad++; $display("FAIL mstart_addr got=%0h@%0h en=%0h exp=06a@0", wr_data, wr_addr, wr_en); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary_fields();
    test_error();
    test_err_codes();
    test_fill();
    test_mid_reset();
    test_mid_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes field-level instruction requests (format, op, registers, immediate) into the 9-bit instruction word that the core's decoder consumes.
- Streams the encoded words into instruction memory through a sequential write port.
- Sits between the testbench/boot program source and instruction memory, and acts as the on-chip assembler back end.
- Checks that every field fits its format and halts on the first illegal request.

Parameters:
ADDR_W, 8, instruction memory address width
DEPTH, 256, maximum words loaded per session (DEPTH <= 2**ADDR_W)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a new load session at address 0
in_valid  input  1  request valid
in_ready  output  1  request can be accepted this cycle
in_last  input  1  marks the final request of the session
fmt  input  3  instruction format select
op  input  3  op/sub-op field
ra  input  3  first register
rb  input  3  second register
imm  input  8  immediate / absolute address
wr_en  output  1  instruction memory write strobe
wr_addr  output  ADDR_W  write address
wr_data  output  9  encoded instruction
done  output  1  session finished (held)
full  output  1  session ended by reaching DEPTH
err  output  1  sticky illegal-request flag
err_code  output  3  cause of the error
count  output  ADDR_W+1  words written this session

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; wr_en=0, wr_addr=0, wr_data=0, done=0, full=0, err=0, err_code=0, count=0.
- Reset mid-session discards any pending write; wr_en is 0 on the cycle after reset.
- States: IDLE, ACTIVE, DONE, ERROR.
  - start in any state moves to ACTIVE and clears count, done, full, err, err_code and the write pointer.
  - start has priority over a same-cycle request.
- in_ready = (state==ACTIVE) && !start && (count + pending write < DEPTH).
  - A transfer occurs when in_valid && in_ready.
- Encoding (combinational from the inputs; registered on accept):
  - fmt0 RR3: {2'b00, op[0], ra, rb}; op<2
  - fmt1 RR2: {2'b01, op, ra[1:0], rb[1:0]}; ra<4, rb<4
  - fmt2 JMP: {3'b100, op[1:0], imm[3:0]}; op<4, imm<16
  - fmt3 R1A: {4'b1010, op[1:0], ra}; op<4
  - fmt4 R1B: {4'b1011, op[1:0], ra}; op<4
  - fmt5 MEMI: {5'b11000, op[0], imm[2:0]}; op<2, imm[7:3]==5'b01000 (absolute addresses 64..71)
  - fmt6 and fmt7 are illegal.
- Legal accept:
  - Next cycle: wr_en=1 for exactly one cycle, wr_addr = current pointer, wr_data = encoded word.
  - Pointer and count increment in the same cycle as wr_en.
  - Latency from accept to write is 1 cycle. Back-to-back accepts give back-to-back writes.
- in_last on a legal accept: the state goes to DONE in the cycle the final write is issued; done rises the cycle after wr_en.
- Fill: when count reaches DEPTH without in_last, go to DONE with done=1 and full=1. in_ready is already low once the DEPTH-th word is pending.
- Illegal accept:
  - No write. err=1.
  - err_code: 1 = bad fmt, 2 = register out of range, 3 = immediate out of range, 4 = op out of range. When several checks fail, the lowest code wins.
  - State goes to ERROR; count holds. Only start or reset leaves ERROR.
- An illegal request carrying in_last is still an error; done stays 0.
- wr_addr wraps naturally only when DEPTH == 2**ADDR_W. The count width is sized to reach DEPTH without wrap.
- Unused field bits are ignored (e.g. rb in fmt2–5, ra and rb in JMP and MEMI) and are never flagged.

Test Plan:
- Reset, start, then fmt0 op=1 ra=5 rb=2 with last -> next cycle wr_en=1, wr_addr=0, wr_data=9'h06A; following cycle done=1, count=1.
- Start; stream fmt2 op=1 imm=9, fmt3 op=2 ra=7, fmt5 op=1 imm=8'h43 (last) on consecutive cycles -> writes 9'h119 @0, 9'h157 @1, 9'h18B @2 on three consecutive cycles; count=3, done=1.
- Start; fmt1 ra=4 rb=0 -> no wr_en, err=1, err_code=2, in_ready=0; then fmt7 before start -> not accepted; start -> err=0, in_ready=1.
- Illegal immediates and ops:
  - fmt5 imm=8'h48 -> err_code=3.
  - fmt2 imm=16 -> err_code=3.
  - fmt0 op=2 -> err_code=4.
  - fmt6 op=5 -> err_code=1 (lowest code wins).
- DEPTH=4, continuous valid without last -> exactly 4 writes to addresses 0..3; in_ready low after 4th accept; full=1, done=1, count=4.
- Mid-session: assert reset one cycle after an accept -> no wr_en, all outputs at reset values. Repeat with start instead of reset, with a same-cycle in_valid -> that request is dropped (in_ready=0) and the next write lands at address 0.
